// File: rtl/mcs4_bus_sched.sv
// mcs4_bus_sched: tracks the i4004 8-phase cycle and schedules ROM fetch,
// SRC latching and RAM/port strobes; publishes a per-byte fetch trace.
// Ports: clk/rst; core side sync, cm_rom, cm_ram, cpu_dout, cpu_din;
// ROM rom_req/rom_addr/rom_rdata; RAM ram_re/we/bank/addr/op/wdata/rdata;
// trace fetch_vld/addr/opc/2nd; instr_cnt; sync_err.
module mcs4_bus_sched #(
  parameter int RST_A1_HOLD = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             cm_rom,
  input  logic [3:0]       cm_ram,
  input  logic [3:0]       cpu_dout,
  output logic [3:0]       cpu_din,
  output logic             rom_req,
  output logic [11:0]      rom_addr,
  input  logic [7:0]       rom_rdata,
  output logic             ram_re,
  output logic             ram_we,
  output logic [1:0]       ram_bank,
  output logic [7:0]       ram_addr,
  output logic [3:0]       ram_op,
  output logic [3:0]       ram_wdata,
  input  logic [3:0]       ram_rdata,
  output logic             fetch_vld,
  output logic [11:0]      fetch_addr,
  output logic [7:0]       fetch_opc,
  output logic             fetch_2nd,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             sync_err
);

  typedef enum logic [2:0] {
    A1, A2, A3, M1, M2, X1, X2, X3
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [7:0]       hold_q;
  logic [3:0]       a_lo_q, a_mid_q;
  logic [11:0]      addr_q;
  logic [7:0]       opc_q;
  logic             second_q, second_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       bank_q, bank_d;
  logic [7:0]       raddr_q;
  logic             err_q;

  // cm_rom is a trace-only line with no consumer here
  wire unused_cm_rom = cm_rom;

  wire [3:0] opr = opc_q[7:4];
  wire [3:0] opa = opc_q[3:0];
  wire is_src = !second_q && opr == 4'h2 && opa[0];
  wire is_io  = !second_q && opr == 4'hE;
  wire is_dbl = (opr == 4'h1) || (opr == 4'h4) ||
                (opr == 4'h5) || (opr == 4'h7) ||
                ((opr == 4'h2 || opr == 4'h3) && !opa[0]);

  assign second_d = !second_q && is_dbl;

  always_comb begin
    bank_d = 2'd3;
    if (cm_ram[0])      bank_d = 2'd0;
    else if (cm_ram[1]) bank_d = 2'd1;
    else if (cm_ram[2]) bank_d = 2'd2;
  end

  // sync always realigns to A1, even when it arrives early
  always_comb begin
    phase_d = phase_e'(phase_q + 3'd1);
    if (sync || hold_q != 8'd0) phase_d = A1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= A1;
      hold_q   <= 8'(RST_A1_HOLD);
      a_lo_q   <= '0;
      a_mid_q  <= '0;
      addr_q   <= '0;
      opc_q    <= '0;
      second_q <= 1'b0;
      cnt_q    <= '0;
      bank_q   <= '0;
      raddr_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (hold_q != 8'd0) hold_q <= hold_q - 8'd1;
      if (sync != (phase_q == X3)) err_q <= 1'b1;
      unique case (phase_q)
        A1: a_lo_q  <= cpu_dout;
        A2: a_mid_q <= cpu_dout;
        A3: addr_q  <= {cpu_dout, a_mid_q, a_lo_q};
        M1: opc_q   <= rom_rdata;
        X2: begin
          if (is_src) begin
            raddr_q[7:4] <= cpu_dout;
            if (cm_ram != 4'd0) bank_q <= bank_d;
          end
        end
        X3: begin
          if (is_src) raddr_q[3:0] <= cpu_dout;
          second_q <= second_d;
          if (!second_d) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_din    = '0;
    rom_req    = 1'b0;
    rom_addr   = '0;
    ram_re     = 1'b0;
    ram_we     = 1'b0;
    ram_op     = '0;
    ram_wdata  = '0;
    fetch_vld  = 1'b0;
    fetch_addr = '0;
    fetch_opc  = '0;
    fetch_2nd  = 1'b0;
    if (!rst) begin
      unique case (phase_q)
        A3: begin
          rom_req  = 1'b1;
          rom_addr = {cpu_dout, a_mid_q, a_lo_q};
        end
        M1: cpu_din = rom_rdata[7:4];
        M2: begin
          cpu_din    = opc_q[3:0];
          fetch_vld  = 1'b1;
          fetch_addr = addr_q;
          fetch_opc  = opc_q;
          fetch_2nd  = second_q;
        end
        X1: begin
          if (is_io) begin
            ram_op = opa;
            ram_re = opa[3];
          end
        end
        X2: begin
          if (is_io) begin
            ram_op = opa;
            if (opa[3]) begin
              cpu_din = ram_rdata;
            end else begin
              ram_we    = 1'b1;
              ram_wdata = cpu_dout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_bank  = bank_q;
  assign ram_addr  = raddr_q;
  assign instr_cnt = cnt_q;
  assign sync_err  = err_q;

endmodule

// File: tb/tb_mcs4_bus_sched.sv
// tb_mcs4_bus_sched: drives the core side of the bus cycle by cycle and
// checks every phase against an instruction-level reference model.
module tb_mcs4_bus_sched;

  logic        clk, rst, sync, cm_rom;
  logic [3:0]  cm_ram, cpu_dout, cpu_din;
  logic        rom_req;
  logic [11:0] rom_addr;
  logic [7:0]  rom_rdata;
  logic        ram_re, ram_we;
  logic [1:0]  ram_bank;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_op, ram_wdata, ram_rdata;
  logic        fetch_vld;
  logic [11:0] fetch_addr;
  logic [7:0]  fetch_opc;
  logic        fetch_2nd;
  logic [15:0] instr_cnt;
  logic        sync_err;

  mcs4_bus_sched #(.RST_A1_HOLD(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sync(sync), .cm_rom(cm_rom),
    .cm_ram(cm_ram), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .ram_re(ram_re), .ram_we(ram_we), .ram_bank(ram_bank),
    .ram_addr(ram_addr), .ram_op(ram_op), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fetch_vld(fetch_vld),
    .fetch_addr(fetch_addr), .fetch_opc(fetch_opc),
    .fetch_2nd(fetch_2nd), .instr_cnt(instr_cnt), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  rom [4096];
  logic        m_second;
  logic [15:0] m_cnt;
  logic [1:0]  m_bank;
  logic [7:0]  m_addr;
  logic        m_err;

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] lowbit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic end_state();
    check("instr_cnt", instr_cnt, m_cnt);
    check("ram_bank", 16'(ram_bank), 16'(m_bank));
    check("ram_addr", 16'(ram_addr), 16'(m_addr));
    check("sync_err", 16'(sync_err), 16'(m_err));
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 1'b0; cpu_dout = '0; cm_ram = '0;
    tick();
    tick();
    @(negedge clk);
    check("rst_rom_req", 16'(rom_req), 16'd0);
    check("rst_cpu_din", 16'(cpu_din), 16'd0);
    check("rst_fetch", 16'(fetch_vld), 16'd0);
    check("rst_strobes", 16'({ram_re, ram_we}), 16'd0);
    m_second = 0; m_cnt = 0; m_bank = 0; m_addr = 0; m_err = 0;
    end_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    // repeated A1 right after reset: no fetch activity yet
    @(negedge clk);
    check("hold_rom_req", 16'(rom_req), 16'd0);
    tick();
  endtask

  // One instruction cycle fetched from pc; x2d/x3d are the core's nibbles
  // in X2/X3; early raises sync in X2; mrst asserts reset in X2.
  task automatic run_cycle(input logic [11:0] pc, input logic [3:0] x2d,
                           input logic [3:0] x3d, input logic [3:0] cmr,
                           input logic [3:0] rrd, input bit early,
                           input bit mrst);
    logic [7:0] opc;
    logic [3:0] opr, opa;
    bit io, src, dbl;
    opc = rom[pc];
    opr = opc[7:4];
    opa = opc[3:0];
    io  = !m_second && opr == 4'hE;
    src = !m_second && opr == 4'h2 && opa[0];
    dbl = opr inside {4'h1, 4'h4, 4'h5, 4'h7} ||
          (opr inside {4'h2, 4'h3} && !opa[0]);
    cm_ram = '0; sync = 1'b0;
    cpu_dout = pc[3:0];
    @(negedge clk);
    check("a1_rom_req", 16'(rom_req), 16'd0);
    check("a1_cpu_din", 16'(cpu_din), 16'd0);
    tick();
    cpu_dout = pc[7:4];
    tick();
    cpu_dout = pc[11:8];
    @(negedge clk);
    check("a3_rom_req", 16'(rom_req), 16'd1);
    check("a3_rom_addr", 16'(rom_addr), 16'(pc));
    tick();
    cpu_dout = 4'($urandom);
    rom_rdata = opc;
    @(negedge clk);
    check("m1_cpu_din", 16'(cpu_din), 16'(opc[7:4]));
    tick();
    rom_rdata = 8'($urandom);
    @(negedge clk);
    check("m2_cpu_din", 16'(cpu_din), 16'(opc[3:0]));
    check("m2_fetch_vld", 16'(fetch_vld), 16'd1);
    check("m2_fetch_addr", 16'(fetch_addr), 16'(pc));
    check("m2_fetch_opc", 16'(fetch_opc), 16'(opc));
    check("m2_fetch_2nd", 16'(fetch_2nd), 16'(m_second));
    tick();
    ram_rdata = 4'($urandom);
    @(negedge clk);
    check("x1_fetch_vld", 16'(fetch_vld), 16'd0);
    check("x1_ram_re", 16'(ram_re), 16'(io && opa[3]));
    check("x1_ram_op", 16'(ram_op), io ? 16'(opa) : 16'd0);
    tick();
    cpu_dout = x2d; cm_ram = cmr; ram_rdata = rrd; sync = early;
    if (mrst) begin
      rst = 1'b1;
      @(negedge clk);
      check("mrst_ram_we", 16'(ram_we), 16'd0);
      check("mrst_ram_op", 16'(ram_op), 16'd0);
      check("mrst_cpu_din", 16'(cpu_din), 16'd0);
      tick();
      return;
    end
    @(negedge clk);
    check("x2_ram_re", 16'(ram_re), 16'd0);
    check("x2_ram_we", 16'(ram_we), 16'(io && !opa[3]));
    check("x2_ram_wdata", 16'(ram_wdata),
          (io && !opa[3]) ? 16'(x2d) : 16'd0);
    check("x2_cpu_din", 16'(cpu_din), (io && opa[3]) ? 16'(rrd) : 16'd0);
    check("x2_ram_op", 16'(ram_op), io ? 16'(opa) : 16'd0);
    tick();
    if (src) begin
      m_addr[7:4] = x2d;
      if (cmr != 4'd0) m_bank = lowbit(cmr);
    end
    if (early) begin
      m_err = 1'b1;
      end_state();
      return;
    end
    cpu_dout = x3d; cm_ram = '0; sync = 1'b1;
    @(negedge clk);
    check("x3_cpu_din", 16'(cpu_din), 16'd0);
    check("x3_ram_we", 16'(ram_we), 16'd0);
    tick();
    if (src) m_addr[3:0] = x3d;
    m_second = !m_second && dbl;
    if (!m_second) m_cnt = m_cnt + 16'd1;
    end_state();
  endtask

  task automatic plain(input logic [11:0] pc);
    run_cycle(pc, 4'($urandom), 4'($urandom), 4'd0, 4'($urandom), 0, 0);
  endtask

  initial begin
    rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; cm_ram = '0;
    cpu_dout = '0; rom_rdata = '0; ram_rdata = '0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
    rom[12'h000] = 8'hD5; rom[12'h001] = 8'h00;
    rom[12'h002] = 8'h41; rom[12'h003] = 8'h23;
    rom[12'h123] = 8'h40; rom[12'h124] = 8'hE0;
    rom[12'h125] = 8'hFD;
    rom[12'h126] = 8'h20; rom[12'h127] = 8'h4A;
    rom[12'h128] = 8'h21;
    rom[12'h129] = 8'hE0; rom[12'h12A] = 8'hE9;
    rom[12'h12B] = 8'hD1; rom[12'h12C] = 8'hD2;
    rom[12'h12D] = 8'hE0;
    @(posedge clk);
    #1;
    do_reset();

    plain(12'h000);
    plain(12'h001);
    check("cnt_after_two", instr_cnt, 16'd2);
    plain(12'h002);
    check("jun_cnt_hold", instr_cnt, 16'd2);
    plain(12'h003);
    check("jun_cnt_done", instr_cnt, 16'd3);
    plain(12'h123);
    plain(12'h124);
    plain(12'h125);
    plain(12'h126);
    plain(12'h127);
    run_cycle(12'h128, 4'h4, 4'hA, 4'b0100, 4'h0, 0, 0);
    check("src_bank", 16'(ram_bank), 16'd2);
    check("src_addr", 16'(ram_addr), 16'h4A);
    run_cycle(12'h129, 4'h7, 4'h0, 4'd0, 4'h3, 0, 0);
    run_cycle(12'h12A, 4'h0, 4'h0, 4'd0, 4'h9, 0, 0);
    run_cycle(12'h12B, 4'h1, 4'h2, 4'd0, 4'h0, 1, 0);
    check("sync_err_set", 16'(sync_err), 16'd1);
    plain(12'h12C);

    for (int n = 0; n < 300; n++) begin
      logic [11:0] pc;
      pc = 12'($urandom);
      run_cycle(pc, 4'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom),
                4'($urandom), $urandom_range(0, 31) == 0, 0);
    end

    do_reset();
    run_cycle(12'h12D, 4'h5, 4'h0, 4'd0, 4'h0, 0, 1);
    do_reset();
    plain(12'h000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
